// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for the VGA pong game.
// Owns scores, serve direction, winner/blink and the match phase, and tells
// the ball datapath whether to move, hold at centre, or freeze. All timing is
// counted in frames using the clk_en-qualified end-of-frame tick.
module pong_match_ctrl #(
   parameter int unsigned WIN_SCORE    = 5,
   parameter int unsigned POINT_FRAMES = 90,
   parameter int unsigned SERVE_FRAMES = 120,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       clk_en,
   input  logic       frame_tick,
   input  logic       run,
   input  logic       serve_btn,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic       ball_enable,
   output logic       ball_center,
   output logic       serve_dir,
   output logic [2:0] score1,
   output logic [2:0] score2,
   output logic       numbers_active,
   output logic [1:0] winner,
   output logic       blink
);

   // Frame counter is wide enough for the longest frame count, never below 8 bits.
   localparam int unsigned MAX_A      = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int unsigned MAX_FRAMES = (MAX_A > BLINK_FRAMES) ? MAX_A : BLINK_FRAMES;
   localparam int unsigned CNT_W      = ($clog2(MAX_FRAMES) > 8) ? $clog2(MAX_FRAMES) : 8;

   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [2:0]       WIN        = 3'(WIN_SCORE);

   typedef enum logic [2:0] {
      IDLE,
      SERVE,
      PLAY,
      POINT,
      OVER,
      PAUSE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             ret_serve;   // 1 = PAUSE was entered from SERVE, 0 = from PLAY

   logic [CNT_W-1:0] cnt_inc;
   logic [2:0]       score1_inc;
   logic [2:0]       score2_inc;

   // Saturating increments for the frame counter and both scores.
   always_comb begin
      cnt_inc    = (cnt == '1) ? cnt : cnt + CNT_W'(1);
      score1_inc = (score1 >= WIN) ? score1 : score1 + 3'd1;
      score2_inc = (score2 >= WIN) ? score2 : score2 + 3'd1;
   end

   // Match FSM with registered outputs; outputs decode the current state, so
   // they follow a state change one enabled cycle later. Reset ignores clk_en.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         ret_serve      <= 1'b0;
         score1         <= '0;
         score2         <= '0;
         serve_dir      <= 1'b0;
         winner         <= 2'b00;
         blink          <= 1'b0;
         ball_enable    <= 1'b0;
         ball_center    <= 1'b1;
         numbers_active <= 1'b1;
      end else if (clk_en) begin
         ball_enable    <= (state == PLAY);
         ball_center    <= (state == IDLE) || (state == SERVE) ||
                           (state == POINT) || (state == OVER);
         numbers_active <= (state == IDLE) || (state == POINT) ||
                           (state == PAUSE) || (state == OVER);

         case (state)
            IDLE: begin
               if (run) begin
                  state <= SERVE;
                  cnt   <= '0;
               end
            end

            SERVE: begin
               if (!run) begin
                  state     <= PAUSE;
                  ret_serve <= 1'b1;
               end else if (serve_btn || (frame_tick && cnt == SERVE_LAST)) begin
                  state <= PLAY;
               end else if (frame_tick) begin
                  cnt <= cnt_inc;
               end
            end

            PLAY: begin
               // miss_left has priority; a simultaneous miss_right is dropped.
               if (miss_left) begin
                  score2    <= score2_inc;
                  serve_dir <= 1'b0;
                  cnt       <= '0;
                  if (score2_inc == WIN) begin
                     state  <= OVER;
                     winner <= 2'b10;
                  end else begin
                     state <= POINT;
                  end
               end else if (miss_right) begin
                  score1    <= score1_inc;
                  serve_dir <= 1'b1;
                  cnt       <= '0;
                  if (score1_inc == WIN) begin
                     state  <= OVER;
                     winner <= 2'b01;
                  end else begin
                     state <= POINT;
                  end
               end else if (!run) begin
                  state     <= PAUSE;
                  ret_serve <= 1'b0;
               end
            end

            POINT: begin
               if (frame_tick) begin
                  if (cnt == POINT_LAST) begin
                     state <= SERVE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end

            PAUSE: begin
               if (run) begin
                  state <= ret_serve ? SERVE : PLAY;
               end
            end

            OVER: begin
               if (frame_tick) begin
                  if (cnt == BLINK_LAST) begin
                     blink <= ~blink;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end

            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: randomized stimulus compared every
// cycle against a phase-level reference model of the match rules.
module tb_pong_match_ctrl;

   localparam int unsigned WIN = 5;
   localparam int unsigned PF  = 90;
   localparam int unsigned SF  = 120;
   localparam int unsigned BF  = 30;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clk_en = 1'b0;
   logic       frame_tick = 1'b0;
   logic       run = 1'b0;
   logic       serve_btn = 1'b0;
   logic       miss_left = 1'b0;
   logic       miss_right = 1'b0;
   logic       ball_enable;
   logic       ball_center;
   logic       serve_dir;
   logic [2:0] score1;
   logic [2:0] score2;
   logic       numbers_active;
   logic [1:0] winner;
   logic       blink;

   pong_match_ctrl #(
      .WIN_SCORE   (WIN),
      .POINT_FRAMES(PF),
      .SERVE_FRAMES(SF),
      .BLINK_FRAMES(BF)
   ) dut (
      .CLOCK_50      (clk),
      .reset         (reset),
      .clk_en        (clk_en),
      .frame_tick    (frame_tick),
      .run           (run),
      .serve_btn     (serve_btn),
      .miss_left     (miss_left),
      .miss_right    (miss_right),
      .ball_enable   (ball_enable),
      .ball_center   (ball_center),
      .serve_dir     (serve_dir),
      .score1        (score1),
      .score2        (score2),
      .numbers_active(numbers_active),
      .winner        (winner),
      .blink         (blink)
   );

   always #10 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference model: match phase by name, frames spent in the current phase,
   // score[0] = left player (1), score[1] = right player (2).
   string m_phase  = "IDLE";
   string m_resume = "PLAY";
   int    m_frames = 0;
   int    m_score[2] = '{0, 0};
   int    m_sdir = 0;
   int    m_winner = 0;
   int    m_blink = 0;
   int    m_be = 0;
   int    m_bc = 1;
   int    m_na = 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      if (reset) begin
         m_phase  = "IDLE";
         m_frames = 0;
         m_score  = '{0, 0};
         m_sdir   = 0;
         m_winner = 0;
         m_blink  = 0;
         m_be     = 0;
         m_bc     = 1;
         m_na     = 1;
         return;
      end
      if (!clk_en) return;
      // visible outputs describe the phase held during the previous enabled cycle
      m_be = (m_phase == "PLAY") ? 1 : 0;
      m_bc = (m_phase != "PLAY" && m_phase != "PAUSE") ? 1 : 0;
      m_na = (m_phase != "SERVE" && m_phase != "PLAY") ? 1 : 0;

      if (m_phase == "IDLE") begin
         if (run) begin
            m_phase  = "SERVE";
            m_frames = 0;
         end
      end else if (m_phase == "SERVE") begin
         if (!run) begin
            m_resume = "SERVE";
            m_phase  = "PAUSE";
         end else if (serve_btn || (frame_tick && m_frames == int'(SF) - 1)) begin
            m_phase = "PLAY";
         end else if (frame_tick) begin
            m_frames++;
         end
      end else if (m_phase == "PLAY") begin
         if (miss_left || miss_right) begin
            automatic int who = miss_left ? 1 : 0;
            if (m_score[who] < int'(WIN)) m_score[who]++;
            m_sdir   = miss_left ? 0 : 1;
            m_frames = 0;
            if (m_score[who] == int'(WIN)) begin
               m_phase  = "OVER";
               m_winner = who + 1;
            end else begin
               m_phase = "POINT";
            end
         end else if (!run) begin
            m_resume = "PLAY";
            m_phase  = "PAUSE";
         end
      end else if (m_phase == "POINT") begin
         if (frame_tick) begin
            if (m_frames == int'(PF) - 1) begin
               m_phase  = "SERVE";
               m_frames = 0;
            end else begin
               m_frames++;
            end
         end
      end else if (m_phase == "PAUSE") begin
         if (run) m_phase = m_resume;
      end else if (m_phase == "OVER") begin
         if (frame_tick) begin
            if (m_frames == int'(BF) - 1) begin
               m_blink  = 1 - m_blink;
               m_frames = 0;
            end else begin
               m_frames++;
            end
         end
      end
   endtask

   task automatic compare_all();
      check_eq("ball_enable", 32'(ball_enable), 32'(m_be));
      check_eq("ball_center", 32'(ball_center), 32'(m_bc));
      check_eq("numbers_active", 32'(numbers_active), 32'(m_na));
      check_eq("serve_dir", 32'(serve_dir), 32'(m_sdir));
      check_eq("score1", 32'(score1), 32'(m_score[0]));
      check_eq("score2", 32'(score2), 32'(m_score[1]));
      check_eq("winner", 32'(winner), 32'(m_winner));
      check_eq("blink", 32'(blink), 32'(m_blink));
   endtask

   task automatic cycle(input logic r, input logic en, input logic ft, input logic rn,
                        input logic sb, input logic ml, input logic mr);
      @(negedge clk);
      reset      = r;
      clk_en     = en;
      frame_tick = ft & en;
      run        = rn;
      serve_btn  = sb;
      miss_left  = ml;
      miss_right = mr;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   // One cycle with randomly gated clk_en and frame_tick.
   task automatic rnd_cycle(input logic rn, input logic sb, input logic ml, input logic mr);
      logic en;
      logic ft;
      en = ($urandom_range(0, 3) != 0);
      ft = en && ($urandom_range(0, 2) == 0);
      cycle(1'b0, en, ft, rn, sb, ml, mr);
   endtask

   task automatic wait_phase(input string target, input logic sb, input int budget);
      int i;
      for (i = 0; i < budget && m_phase != target; i++) rnd_cycle(1'b1, sb, 1'b0, 1'b0);
      check_eq({"reach_", target}, 32'(m_phase == target), 32'd1);
   endtask

   initial begin
      int ticks;
      logic en;
      logic ft;

      // reset state
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("rst_ball_center", 32'(ball_center), 32'd1);
      check_eq("rst_ball_enable", 32'(ball_enable), 32'd0);

      // automatic serve on the 120th frame tick
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks = 0;
      for (int i = 0; i < 5000 && ticks < int'(SF); i++) begin
         en = ($urandom_range(0, 3) != 0);
         ft = en && ($urandom_range(0, 1) == 0);
         if (ft) ticks++;
         cycle(1'b0, en, ft, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("auto_serve_play", 32'(ball_enable), 32'd1);

      // miss_right -> point for player 1, overlay, then back to serve
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("pt_score1", 32'(score1), 32'd1);
      check_eq("pt_serve_dir", 32'(serve_dir), 32'd1);
      check_eq("pt_numbers", 32'(numbers_active), 32'd1);
      wait_phase("SERVE", 1'b0, 5000);
      wait_phase("PLAY", 1'b1, 50);

      // simultaneous misses: left wins
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("both_score2", 32'(score2), 32'd1);
      check_eq("both_score1", 32'(score1), 32'd1);

      // pause from SERVE and return
      wait_phase("SERVE", 1'b0, 5000);
      for (int i = 0; i < 6; i++) rnd_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) rnd_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      wait_phase("PLAY", 1'b1, 50);

      // pause from PLAY (misses while paused are ignored) and return
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("pause_ball_center", 32'(ball_center), 32'd0);
      check_eq("pause_ball_enable", 32'(ball_enable), 32'd0);
      for (int i = 0; i < 6; i++) rnd_cycle(1'b1, 1'b0, 1'b0, 1'b0);

      // reset during POINT while clk_en is low
      wait_phase("PLAY", 1'b1, 50);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) rnd_cycle(1'b1, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("rstpt_score1", 32'(score1), 32'd0);
      check_eq("rstpt_score2", 32'(score2), 32'd0);
      check_eq("rstpt_winner", 32'(winner), 32'd0);
      check_eq("rstpt_blink", 32'(blink), 32'd0);

      // five left misses with serve held -> player 2 wins
      for (int i = 0; i < 20000 && m_phase != "OVER"; i++) begin
         if (m_phase == "PLAY") cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
         else rnd_cycle(1'b1, 1'b1, 1'b0, 1'b0);
      end
      check_eq("reach_OVER", 32'(m_phase == "OVER"), 32'd1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("over_winner", 32'(winner), 32'd2);
      check_eq("over_score2", 32'(score2), 32'd5);
      for (int i = 0; i < 800; i++)
         rnd_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_eq("over_hold_score2", 32'(score2), 32'd5);

      // random soak with occasional resets
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6000; i++) begin
         en = ($urandom_range(0, 3) != 0);
         ft = en && ($urandom_range(0, 2) == 0);
         cycle(1'($urandom_range(0, 1999) == 0), en, ft,
               1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 24) == 0),
               1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 29) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match sequencer for the VGA pong game. It owns scores, serve direction and match phase, and tells the ball datapath when to move, hold at centre, or freeze. It sits between the frame-rate game logic (paddle/ball update in the CLK_25 domain) and the drawing/7-segment logic, and replaces ad-hoc score and switch handling with one state machine. All timing is counted in frames, using the end-of-frame tick.

Parameters:
WIN_SCORE, 5, score that ends the match (1..7)
POINT_FRAMES, 90, frames the score overlay is held after a point
SERVE_FRAMES, 120, frames in SERVE before an automatic serve
BLINK_FRAMES, 30, frames per half-period of the winner blink

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_en  in  1  single-cycle enable (25 MHz pixel strobe); all state advances only when high
frame_tick  in  1  one clk_en-qualified pulse per frame (v_count wrap)
run  in  1  level; 0 = pause (SW[9]-style run switch)
serve_btn  in  1  level, active-high, serve request
miss_left  in  1  pulse; ball passed the left goal line
miss_right  in  1  pulse; ball passed the right goal line
ball_enable  out  1  1 = ball datapath may move the ball this frame
ball_center  out  1  1 = ball datapath holds ball at (320,240), UD=0
serve_dir  out  1  0 = serve toward left player, 1 = toward right
score1  out  3  player 1 (left) score
score2  out  3  player 2 (right) score
numbers_active  out  1  1 = draw on-screen score digits
winner  out  2  00 none, 01 player 1, 10 player 2
blink  out  1  winner blink phase

Behaviour:
- Every register updates only on posedge CLOCK_50 with clk_en=1; reset wins over clk_en and has priority over all other inputs.
- Reset values: state=IDLE, score1=score2=0, serve_dir=0, winner=00, blink=0, frame counter=0. Outputs: ball_enable=0, ball_center=1, numbers_active=1.
- States: IDLE, SERVE, PLAY, POINT, OVER, PAUSE.
- IDLE: ball_center=1, numbers_active=1. run=1 -> SERVE, frame counter cleared.
- SERVE: ball_center=1, numbers_active=0. The frame counter increments on frame_tick. serve_btn=1 or counter==SERVE_FRAMES-1 at a frame_tick -> PLAY. run=0 -> PAUSE.
- PLAY: ball_enable=1, ball_center=0, numbers_active=0.
  - miss_left -> score2+1, serve_dir<=0.
  - miss_right -> score1+1, serve_dir<=1.
  - Both pulses in the same cycle: miss_left wins and miss_right is discarded.
  - After a point: new score==WIN_SCORE -> OVER, winner set; otherwise -> POINT, counter cleared.
  - run=0 with no miss -> PAUSE.
- POINT: ball_enable=0, ball_center=1, numbers_active=1. A frame_tick with counter==POINT_FRAMES-1 -> SERVE, counter cleared. run is ignored and miss pulses are ignored.
- PAUSE: ball_enable=0, ball_center=0 (ball frozen in place), numbers_active=1. run=1 -> PLAY if entered from PLAY, SERVE if entered from SERVE; a 1-bit return flag stores which.
- OVER: ball_enable=0, ball_center=1, numbers_active=1. blink toggles on the frame_tick where counter==BLINK_FRAMES-1, and the counter wraps to 0. Scores hold. Only reset leaves OVER; run, serve_btn and miss pulses are ignored.
- blink=0 in every state except OVER.
- Miss pulses outside PLAY are ignored and never change a score.
- Scores never exceed WIN_SCORE and never wrap.
- The frame counter is sized for the largest parameter (8 bits minimum) and saturates rather than wraps, except for the blink wrap in OVER.
- Outputs are registered, so an output reflects a state change one enabled cycle after the transition.
- Reset mid-PLAY or mid-POINT: next enabled cycle is IDLE with both scores 0.

Test Plan:
- Reset, then run=1 and 120 frame_ticks with serve_btn=0 -> IDLE->SERVE, PLAY entered on the 120th tick; ball_enable=1.
- In PLAY, a miss_right pulse -> score1=1, serve_dir=1, POINT state, numbers_active=1 for exactly 90 frames, then SERVE.
- miss_left and miss_right in the same cycle -> score2=1 and score1 unchanged.
- Five miss_left points with serve_btn held -> after the fifth: winner=10, score2=5, state OVER. blink toggles every 30 frames, and further miss pulses leave the scores at 5.
- run=0 in PLAY -> ball_enable=0, ball_center=0. run=1 -> back to PLAY with scores unchanged. The same sequence from SERVE returns to SERVE.
- Reset asserted during POINT with clk_en=0 -> IDLE on the next CLOCK_50 edge; scores 0, winner=00, blink=0.
